wb_stage: RTL and testbench

Writeback stage of the 5-stage in-order pipeline. It consumes the MA→WB payload (`Ma_Wb_t`) over a ready/valid handshake and selects the writeback value: load data, return address, or ALU result. It drives a registered single-port write into the register file and emits a retire pulse per instruction. It also latches a HALTED state when a `hlt` instruction retires, which stops further intake.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/wb_mux.sv | 41 ++++
 rtl/wb_stage.sv | 121 ++++++++++++
 tb/tb_wb_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: MA->WB payload, control flags, writeback constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_XLEN   = 32;
    localparam int RA_REG_IDX = 15;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 22;

    // Decoded control flags carried down the pipe with each instruction
    typedef struct packed {
        logic isLd;
        logic isSt;
        logic isBr;
        logic isWb;
        logic isCall;
        logic isHlt;
    } ctrl_t;

    // MA -> WB pipe register contents
    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] instr;
        logic [CPU_XLEN-1:0] aluresult;
        logic [CPU_XLEN-1:0] ld_data;
        ctrl_t               ctrl;
    } Ma_Wb_t;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_mux.sv
// Writeback selection: write enable, destination index and value from an MA->WB payload.
// Latency: purely combinational (0 cycles); shared with the hazard unit for forwarding.
// Backpressure: none; the caller decides when the outputs are meaningful.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int RA_REG         = RA_REG_IDX
) (
    input  Ma_Wb_t                    Payld_i,
    output logic                      We_o,
    output logic [REG_ADDR_WIDTH-1:0] Dest_o,
    output logic [DATA_WIDTH-1:0]     Value_o
);

    // Fields that play no part in writeback selection
    logic unused_payld;
    assign unused_payld = ^{Payld_i.instr[CPU_XLEN-1:RD_MSB+1],
                            Payld_i.instr[RD_LSB-1:0],
                            Payld_i.ctrl.isSt,
                            Payld_i.ctrl.isBr,
                            Payld_i.ctrl.isHlt};

    // Select enable, destination and value; load data wins over the call return address
    always_comb begin
        We_o    = Payld_i.ctrl.isWb;
        Dest_o  = REG_ADDR_WIDTH'(Payld_i.instr[RD_MSB:RD_LSB]);
        Value_o = DATA_WIDTH'(Payld_i.aluresult);
        if (Payld_i.ctrl.isCall) begin
            Dest_o = REG_ADDR_WIDTH'(RA_REG);
        end
        if (Payld_i.ctrl.isLd) begin
            Value_o = DATA_WIDTH'(Payld_i.ld_data);
        end else if (Payld_i.ctrl.isCall) begin
            // Return address wraps naturally at the data width
            Value_o = DATA_WIDTH'(Payld_i.pc) + DATA_WIDTH'(4);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registered register-file write, retire pulse, sticky HALTED on hlt.
// Latency: accept at edge N -> Rf_W*_o / Retire_*_o valid in cycle N+1; 1 instr/cycle.
// Backpressure: Ma_Ready_o is high only in RUN; HALTED stalls MA until reset. Optional Instret_o with WB_INSTRET_EN.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int RA_REG         = RA_REG_IDX,
    parameter int INSTRET_WIDTH  = 64
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  Ma_Wb_t                    Ma_Payld_i,
    input  logic                      Ma_Valid_i,
    output logic                      Ma_Ready_o,
    output logic                      Rf_Wen_o,
    output logic [REG_ADDR_WIDTH-1:0] Rf_Waddr_o,
    output logic [DATA_WIDTH-1:0]     Rf_Wdata_o,
    output logic                      Retire_Valid_o,
    output logic [DATA_WIDTH-1:0]     Retire_Pc_o,
`ifdef WB_INSTRET_EN
    output logic [INSTRET_WIDTH-1:0]  Instret_o,
`endif
    output logic                      Halted_o
);

    wb_state_e                 state_q, state_d;
    logic                      rf_wen_q, rf_wen_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
    logic                      retire_vld_q, retire_vld_d;
    logic [DATA_WIDTH-1:0]     retire_pc_q, retire_pc_d;
`ifdef WB_INSTRET_EN
    logic [INSTRET_WIDTH-1:0]  instret_q, instret_d;
`else
    logic [INSTRET_WIDTH-1:0]  unused_instret_w;
    assign unused_instret_w = '0;
`endif

    logic                      accept;
    logic                      mux_we;
    logic [REG_ADDR_WIDTH-1:0] mux_dest;
    logic [DATA_WIDTH-1:0]     mux_value;

    wb_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .RA_REG         (RA_REG)
    ) u_wb_mux (
        .Payld_i (Ma_Payld_i),
        .We_o    (mux_we),
        .Dest_o  (mux_dest),
        .Value_o (mux_value)
    );

    assign Ma_Ready_o = (state_q == WB_RUN);
    assign accept     = Ma_Valid_i && Ma_Ready_o;

    // Next state: payload is only sampled on accept, so an idle or X payload never reaches the outputs
    always_comb begin
        state_d      = state_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_vld_d = 1'b0;
        retire_pc_d  = retire_pc_q;
`ifdef WB_INSTRET_EN
        instret_d    = instret_q;
`endif
        if (accept) begin
            rf_wen_d     = mux_we;
            rf_waddr_d   = mux_dest;
            rf_wdata_d   = mux_value;
            retire_vld_d = 1'b1;
            retire_pc_d  = DATA_WIDTH'(Ma_Payld_i.pc);
`ifdef WB_INSTRET_EN
            instret_d    = instret_q + INSTRET_WIDTH'(1);
`endif
            if (Ma_Payld_i.ctrl.isHlt) begin
                state_d = WB_HALTED;
            end
        end
    end

    // RUN/HALTED state and all registered outputs; reset drops any in-flight write at once
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= WB_RUN;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retire_vld_q <= 1'b0;
            retire_pc_q  <= '0;
`ifdef WB_INSTRET_EN
            instret_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            retire_vld_q <= retire_vld_d;
            retire_pc_q  <= retire_pc_d;
`ifdef WB_INSTRET_EN
            instret_q    <= instret_d;
`endif
        end
    end

    assign Rf_Wen_o       = rf_wen_q;
    assign Rf_Waddr_o     = rf_waddr_q;
    assign Rf_Wdata_o     = rf_wdata_q;
    assign Retire_Valid_o = retire_vld_q;
    assign Retire_Pc_o    = retire_pc_q;
    assign Halted_o       = (state_q == WB_HALTED);
`ifdef WB_INSTRET_EN
    assign Instret_o      = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written halt/reset sequences, random traffic.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: holds valid payloads against a halted stage to confirm nothing is taken.
module tb_wb_stage;
    import cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    Ma_Wb_t      payld;
    logic        valid;
    logic        ready;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ret_vld;
    logic [31:0] ret_pc;
    logic        halted;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    always #5 Clk = ~Clk;

    wb_stage dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Ma_Payld_i     (payld),
        .Ma_Valid_i     (valid),
        .Ma_Ready_o     (ready),
        .Rf_Wen_o       (rf_wen),
        .Rf_Waddr_o     (rf_waddr),
        .Rf_Wdata_o     (rf_wdata),
        .Retire_Valid_o (ret_vld),
        .Retire_Pc_o    (ret_pc),
`ifdef WB_INSTRET_EN
        .Instret_o      (instret),
`endif
        .Halted_o       (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the architectural effect of retired instructions
    logic        m_wen, m_rvld, m_halted;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata, m_rpc;
    longint unsigned m_cnt;

    typedef struct {
        logic [31:0] pc;
        int          rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        wb, isld, call, st;
        logic        exp_wen;
        int          exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic Ma_Wb_t mk(input logic [31:0] pc, input int rd, input logic [31:0] alu,
                                  input logic [31:0] ld, input logic wb, input logic isld,
                                  input logic call, input logic st, input logic hlt);
        Ma_Wb_t p;
        p.pc          = pc;
        p.instr       = 32'hFC00_0ABC | (32'(rd % 16) << 22);
        p.aluresult   = alu;
        p.ld_data     = ld;
        p.ctrl.isLd   = isld;
        p.ctrl.isSt   = st;
        p.ctrl.isBr   = 1'b0;
        p.ctrl.isWb   = wb;
        p.ctrl.isCall = call;
        p.ctrl.isHlt  = hlt;
        return p;
    endfunction

    task automatic model_reset();
        m_wen = 1'b0; m_rvld = 1'b0; m_halted = 1'b0;
        m_waddr = 4'd0; m_wdata = 32'd0; m_rpc = 32'd0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wen"},    64'(rf_wen),   64'(m_wen));
        check({tag, ".waddr"},  64'(rf_waddr), 64'(m_waddr));
        check({tag, ".wdata"},  64'(rf_wdata), 64'(m_wdata));
        check({tag, ".retvld"}, 64'(ret_vld),  64'(m_rvld));
        check({tag, ".retpc"},  64'(ret_pc),   64'(m_rpc));
        check({tag, ".halted"}, 64'(halted),   64'(m_halted));
        check({tag, ".ready"},  64'(ready),    64'(!m_halted));
`ifdef WB_INSTRET_EN
        check({tag, ".instret"}, instret, m_cnt);
`endif
    endtask

    // Drive one cycle, update the model from the architectural rules, then compare
    task automatic apply(input logic v, input Ma_Wb_t p, input string tag);
        logic taken;
        valid = v;
        payld = p;
        taken = v && !m_halted;
        @(posedge Clk);
        #1;
        if (taken) begin
            m_wen   = p.ctrl.isWb;
            m_waddr = p.ctrl.isCall ? 4'd15 : 4'((p.instr >> 22) % 16);
            if (p.ctrl.isLd)        m_wdata = p.ld_data;
            else if (p.ctrl.isCall) m_wdata = 32'((64'(p.pc) + 64'd4) % 64'h1_0000_0000);
            else                    m_wdata = p.aluresult;
            m_rvld = 1'b1;
            m_rpc  = p.pc;
            m_cnt  = m_cnt + 1;
            if (p.ctrl.isHlt) m_halted = 1'b1;
        end else begin
            m_wen  = 1'b0;
            m_rvld = 1'b0;
        end
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        Ma_Wb_t junk;
        junk = mk($urandom, int'($urandom_range(0, 15)), $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b0, junk, tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"},  64'(ready),    64'd1);
        check({tag, ".wen"},    64'(rf_wen),   64'd0);
        check({tag, ".waddr"},  64'(rf_waddr), 64'd0);
        check({tag, ".wdata"},  64'(rf_wdata), 64'd0);
        check({tag, ".retvld"}, 64'(ret_vld),  64'd0);
        check({tag, ".retpc"},  64'(ret_pc),   64'd0);
        check({tag, ".halted"}, 64'(halted),   64'd0);
`ifdef WB_INSTRET_EN
        check({tag, ".instret"}, instret, 64'd0);
`endif
    endtask

    // Reset asynchronously away from the edge, check immediately, release on a falling edge
    task automatic pulse_reset(input string tag);
        Rst_n = 1'b0;
        valid = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   vecs[6];
        Ma_Wb_t p;

        vecs[0] = '{32'h100, 3, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'hDEADBEEF};
        vecs[1] = '{32'h104, 5, 32'h40, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5, 32'h1234};
        vecs[2] = '{32'hFFFFFFFC, 7, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15, 32'h0};
        vecs[3] = '{32'h10C, 2, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h99};
        vecs[4] = '{32'h110, 0, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h55};
        vecs[5] = '{32'h200, 9, 32'h77, 32'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 15, 32'hCAFE};

        Rst_n = 1'b0;
        valid = 1'b0;
        payld = mk(32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_reset_vals("reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Directed vectors, each followed by an idle cycle
        foreach (vecs[i]) begin
            p = mk(vecs[i].pc, vecs[i].rd, vecs[i].alu, vecs[i].ld, vecs[i].wb,
                   vecs[i].isld, vecs[i].call, vecs[i].st, 1'b0);
            apply(1'b1, p, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_wen", i),   64'(rf_wen),   64'(vecs[i].exp_wen));
            check($sformatf("vec%0d.tbl_waddr", i), 64'(rf_waddr), 64'(vecs[i].exp_waddr));
            check($sformatf("vec%0d.tbl_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_wdata));
            check($sformatf("vec%0d.tbl_retpc", i), 64'(ret_pc),   64'(vecs[i].pc));
            idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d.idle_waddr_hold", i), 64'(rf_waddr), 64'(vecs[i].exp_waddr));
        end

        // Four back-to-back ALU ops form a continuous write train
        for (int i = 0; i < 4; i++) begin
            p = mk(32'h300 + 32'(4 * i), i + 8, 32'hA000 + 32'(i), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            apply(1'b1, p, $sformatf("b2b%0d", i));
            check($sformatf("b2b%0d.train", i), 64'(rf_wen), 64'd1);
        end
        idle("b2b_gap");
        check("b2b_gap.wen_low", 64'(rf_wen), 64'd0);

        // Randomized traffic, no halts
        for (int c = 0; c < 300; c++) begin
            p = mk($urandom, int'($urandom_range(0, 15)), $urandom, $urandom,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            apply($urandom_range(0, 3) != 0, p, $sformatf("rnd%0d", c));
        end

        // hlt retires, then a held valid ALU op is never taken
        p = mk(32'h400, 4, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply(1'b1, p, "hlt");
        check("hlt.halted", 64'(halted), 64'd1);
        check("hlt.ready",  64'(ready),  64'd0);
        check("hlt.retvld", 64'(ret_vld), 64'd1);
        p = mk(32'h404, 6, 32'hBAD, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, p, $sformatf("halted_hold%0d", i));
            check($sformatf("halted_hold%0d.nowrite", i), 64'(rf_wen), 64'd0);
        end

        // Reset clears HALTED, then reset lands the cycle after an accept
        pulse_reset("rst_halt");
        p = mk(32'h500, 12, 32'h600D, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, p, "pre_rst");
        pulse_reset("rst_mid");
        p = mk(32'h504, 13, 32'hF00D, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, p, "post_rst");
        check("post_rst.wdata_abs", 64'(rf_wdata), 64'h0000_F00D);
        idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
